inst_mem_fetch: RTL and testbench
=================================

Name: inst_mem_fetch

Overview:
- Parametrised, synthesisable instruction memory with a registered fetch port and a loader write port.
- Sits between the PC/IF stage and the IF/ID register. Replaces the combinational ROM.
- Adds a one-cycle registered read with valid/ready back-pressure, pipeline flush, and run-time program loading.
- Out-of-range fetches return the NOP word and raise a fault flag.

Parameters:
- INST_W, 19, instruction width in bits
- ADDR_W, 12, PC width (word-addressed; PC value = word index)
- DEPTH, 16, number of implemented words (DEPTH <= 2**ADDR_W)
- NOP_WORD, 19'b0, word returned for out-of-range or flushed fetches

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request present
- req_pc  in  ADDR_W  word address to fetch
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- resp_valid  out  1  response register holds a valid instruction
- resp_ready  in  1  IF/ID consumes response
- resp_instr  out  INST_W  fetched instruction
- resp_pc  out  ADDR_W  PC of resp_instr
- resp_fault  out  1  resp_pc >= DEPTH
- flush  in  1  discard held response (branch taken)
- ld_we  in  1  loader write enable
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  INST_W  loader write data

Behaviour:
- Reset (async assert, sync-release use): resp_valid=0, resp_instr=NOP_WORD, resp_pc=0, resp_fault=0. Array contents are not reset; they are only written by the loader or by the optional init.
- req_ready = !flush && (!resp_valid || resp_ready). This is combinational and gives a single-entry skid-free pipeline.
- Accept (req_valid && req_ready) at edge N: at N+1, resp_valid=1, resp_pc=req_pc, and resp_instr is either mem[req_pc] or NOP_WORD.
  - resp_fault=1 if req_pc >= DEPTH, and resp_instr=NOP_WORD in that case.
- Hold: if resp_valid && !resp_ready && !flush, all resp_* outputs stay stable.
- Drain: if resp_valid && resp_ready and there is no accept, resp_valid=0 next cycle. resp_instr/pc/fault keep their last values.
- Flush: takes priority over everything. resp_valid=0 next cycle and no request is accepted in that cycle (req_ready=0).
- Loader write: mem[ld_addr] <= ld_data at the edge when ld_we=1 and ld_addr < DEPTH. Writes to ld_addr >= DEPTH are ignored.
- Same-cycle write and accepted read to the same address: write-first. resp_instr returns ld_data (bypass).
- Reset asserted mid-hold: the response is discarded immediately (async). Memory keeps its contents.
- Throughput: 1 fetch/cycle while resp_ready=1. Latency: 1 cycle.

Optional Feature:
- Macro INST_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on the loader write.
  - On read, the stored parity is checked.
  - Adds output port parity_err (1 bit, registered with the response). It is high alongside resp_valid when the stored parity mismatches. Reset value 0.
  - Faulted (out-of-range) fetches report parity_err=0.
- Undefined: no parity storage and no parity_err port. Behaviour is otherwise identical.

Decomposition:
- Package inst_mem_pkg holds:
  - INST_W_DEF=19 and ADDR_W_DEF=12
  - NOP constant
  - typedef inst_t (logic [INST_W_DEF-1:0])
  - typedef fetch_resp_t struct {instr, pc, fault}
- Sub-module inst_mem_array holds the storage only: DEPTH x (INST_W[+1]) registers, one synchronous write port and one combinational read port.
- The top level owns:
  - range check
  - write-first bypass
  - handshake and flush logic
  - response register
  - parity check

Test Plan:
1. Load mem[0]=19'b0000011100000000000 and mem[1]=19'b0000000100000000000, then fetch pc 0,1 back-to-back with resp_ready=1 → resp_valid on consecutive cycles, instrs match, resp_fault=0.
2. Fetch pc=20 (DEPTH=16) → after 1 cycle resp_valid=1, resp_instr=0, resp_fault=1, resp_pc=20.
3. Fetch pc=2, then hold resp_ready=0 for 3 cycles while req_valid=1 → req_ready=0 and resp_* stable throughout. After resp_ready=1, the next pc is accepted.
4. Assert flush while resp_valid=1 and req_valid=1 → resp_valid=0 next cycle, no accept in the flush cycle, resp_pc unchanged.
5. Same cycle: ld_we=1, ld_addr=3, ld_data=19'b1010000000000000110, and accepted fetch of pc=3 → resp_instr=19'b1010000000000000110 (write-first).
6. Pull rst_n low while a response is held → resp_valid=0 immediately. After release, a re-fetch of pc 0 returns the previously loaded word.
   - With INST_MEM_PARITY_EN defined, also force a stored parity bit flip → parity_err=1 on that fetch.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types and defaults for the instruction fetch memory.
// Optional build macro: INST_MEM_PARITY_EN adds a stored parity bit per word.
package inst_mem_pkg;

  localparam int INST_W_DEF = 19;
  localparam int ADDR_W_DEF = 12;

  typedef logic [INST_W_DEF-1:0] inst_t;

  // Word handed to IF/ID for flushed or out-of-range fetches.
  localparam inst_t NOP = '0;

  typedef struct packed {
    inst_t                 instr;
    logic [ADDR_W_DEF-1:0] pc;
    logic                  fault;
  } fetch_resp_t;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: DEPTH x W registers, one synchronous write port and
// one combinational read port. No reset; contents come from the loader only.
module inst_mem_array #(
  parameter int W     = 19,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // Loader write; the caller has already range-checked the address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_fetch.sv
// Registered instruction fetch port with valid/ready back-pressure, flush,
// a run-time loader write port and write-first bypass.
// Optional build macro: INST_MEM_PARITY_EN stores an even-parity bit per word
// and adds the registered parity_err output.
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int                INST_W   = INST_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 16,
  parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [INST_W-1:0] resp_instr,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
`ifdef INST_MEM_PARITY_EN
  input  logic [INST_W-1:0] ld_data,
  output logic              parity_err
`else
  input  logic [INST_W-1:0] ld_data
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef INST_MEM_PARITY_EN
  localparam int WORD_W = INST_W + 1;
`else
  localparam int WORD_W = INST_W;
`endif

  logic              accept_p0;
  logic              in_range_p0;
  logic              wr_en_p0;
  logic              bypass_p0;
  logic [WORD_W-1:0] wr_word_p0;
  logic [WORD_W-1:0] arr_word_p0;
  logic [WORD_W-1:0] rd_word_p0;
  logic [INST_W-1:0] instr_p0;

  logic              vld_p1;
  logic [INST_W-1:0] instr_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              fault_p1;

  // Stage p0: request decode, range check, loader gating and bypass select
  assign req_ready   = !flush && (!vld_p1 || resp_ready);
  assign accept_p0   = req_valid && req_ready;
  assign in_range_p0 = {1'b0, req_pc} < DEPTH_L;
  assign wr_en_p0    = ld_we && ({1'b0, ld_addr} < DEPTH_L);
  assign bypass_p0   = wr_en_p0 && (ld_addr == req_pc);

`ifdef INST_MEM_PARITY_EN
  // Even parity: the stored bit makes the whole word's XOR zero.
  assign wr_word_p0 = {^ld_data, ld_data};
`else
  assign wr_word_p0 = ld_data;
`endif

  inst_mem_array #(
    .W     (WORD_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_p0),
    .waddr (ld_addr[IDX_W-1:0]),
    .wdata (wr_word_p0),
    .raddr (req_pc[IDX_W-1:0]),
    .rdata (arr_word_p0)
  );

  // A write landing on the fetched address this cycle wins over the old word.
  assign rd_word_p0 = bypass_p0 ? wr_word_p0 : arr_word_p0;
  assign instr_p0   = in_range_p0 ? rd_word_p0[INST_W-1:0] : NOP_WORD;

`ifdef INST_MEM_PARITY_EN
  logic perr_p0;
  logic perr_p1;

  assign perr_p0 = in_range_p0 && (^rd_word_p0);

  // Parity flag travels with the response and drops whenever valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_p1 <= 1'b0;
    end else if (flush) begin
      perr_p1 <= 1'b0;
    end else if (accept_p0) begin
      perr_p1 <= perr_p0;
    end else if (resp_ready) begin
      perr_p1 <= 1'b0;
    end
  end

  assign parity_err = perr_p1;
`endif

  // Stage p1: response register (flush > accept > drain > hold)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_WORD;
      pc_p1    <= '0;
      fault_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      instr_p1 <= instr_p0;
      pc_p1    <= req_pc;
      fault_p1 <= !in_range_p0;
    end else if (resp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign resp_valid = vld_p1;
  assign resp_instr = instr_p1;
  assign resp_pc    = pc_p1;
  assign resp_fault = fault_p1;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch: load, fetch, range fault, hold, flush,
// write-first bypass and asynchronous reset during a held response.
module tb_inst_mem_fetch;
  localparam int INST_W = 19;
  localparam int ADDR_W = 12;

  localparam logic [INST_W-1:0] M0   = 19'b0000011100000000000;
  localparam logic [INST_W-1:0] M1   = 19'b0000000100000000000;
  localparam logic [INST_W-1:0] M2   = 19'h2A5A5;
  localparam logic [INST_W-1:0] OLD3 = 19'h12345;
  localparam logic [INST_W-1:0] NEW3 = 19'b1010000000000000110;
  localparam logic [INST_W-1:0] M15  = 19'h50F0F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_pc = '0;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [INST_W-1:0] resp_instr;
  logic [ADDR_W-1:0] resp_pc;
  logic              resp_fault;
  logic              flush = 1'b0;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [INST_W-1:0] ld_data = '0;
`ifdef INST_MEM_PARITY_EN
  logic              parity_err;
`endif

  int checks = 0;
  int errors = 0;

  inst_mem_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_pc    (resp_pc),
    .resp_fault (resp_fault),
    .flush      (flush),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
`ifdef INST_MEM_PARITY_EN
    .ld_data    (ld_data),
    .parity_err (parity_err)
`else
    .ld_data    (ld_data)
`endif
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    checks++; if (resp_instr !== '0) begin errors++; $display("FAIL reset_instr got %h want 0", resp_instr); end
    checks++; if (resp_pc !== '0) begin errors++; $display("FAIL reset_pc got %0d want 0", resp_pc); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", resp_fault); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    load(0, M0); load(1, M1); load(2, M2); load(3, OLD3); load(15, M15);
    req_valid = 1'b1; req_pc = 0; resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 0 || resp_instr !== M0 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_pc0 got v=%b pc=%0d i=%h f=%b want v=1 pc=0 i=%h f=0", resp_valid, resp_pc, resp_instr, resp_fault, M0); end
    req_pc = 1;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 1 || resp_instr !== M1 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_pc1 got v=%b pc=%0d i=%h f=%b want v=1 pc=1 i=%h f=0", resp_valid, resp_pc, resp_instr, resp_fault, M1); end
    req_pc = 15;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 15 || resp_instr !== M15 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_pc15 got v=%b pc=%0d i=%h f=%b want v=1 pc=15 i=%h f=0", resp_valid, resp_pc, resp_instr, resp_fault, M15); end
    req_valid = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b0 || resp_instr !== M15 || resp_pc !== 15) begin
      errors++; $display("FAIL drain got v=%b pc=%0d i=%h want v=0 pc=15 i=%h", resp_valid, resp_pc, resp_instr, M15); end
  endtask

  task automatic test_out_of_range();
    req_valid = 1'b1; req_pc = 20; resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 20 || resp_instr !== '0 || resp_fault !== 1'b1) begin
      errors++; $display("FAIL oor_pc20 got v=%b pc=%0d i=%h f=%b want v=1 pc=20 i=0 f=1", resp_valid, resp_pc, resp_instr, resp_fault); end
    req_pc = 16;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 16 || resp_instr !== '0 || resp_fault !== 1'b1) begin
      errors++; $display("FAIL oor_pc16 got v=%b pc=%0d i=%h f=%b want v=1 pc=16 i=0 f=1", resp_valid, resp_pc, resp_instr, resp_fault); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    req_valid = 1'b1; req_pc = 2; resp_ready = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 2 || resp_instr !== M2) begin
      errors++; $display("FAIL hold_first got v=%b pc=%0d i=%h want v=1 pc=2 i=%h", resp_valid, resp_pc, resp_instr, M2); end
    req_pc = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, req_ready); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_pc !== 2 || resp_instr !== M2 || resp_fault !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d] got v=%b pc=%0d i=%h f=%b want v=1 pc=2 i=%h f=0", i, resp_valid, resp_pc, resp_instr, resp_fault, M2); end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 1 || resp_instr !== M1) begin
      errors++; $display("FAIL hold_next got v=%b pc=%0d i=%h want v=1 pc=1 i=%h", resp_valid, resp_pc, resp_instr, M1); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_pc = 0; resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_pc !== 0) begin
      errors++; $display("FAIL flush_pre got v=%b pc=%0d want v=1 pc=0", resp_valid, resp_pc); end
    flush = 1'b1; req_pc = 1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b0 || resp_pc !== 0) begin
      errors++; $display("FAIL flush_result got v=%b pc=%0d want v=0 pc=0", resp_valid, resp_pc); end
    flush = 1'b0; req_valid = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_after got v=%b want 0", resp_valid); end
  endtask

  task automatic test_write_first();
    resp_ready = 1'b1;
    ld_we = 1'b1; ld_addr = 3; ld_data = NEW3;
    req_valid = 1'b1; req_pc = 3;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_instr !== NEW3) begin
      errors++; $display("FAIL write_first got v=%b i=%h want v=1 i=%h", resp_valid, resp_instr, NEW3); end
    ld_we = 1'b0; req_valid = 1'b0;
    step();
    load(19, 19'h7FFFF);
    req_valid = 1'b1; req_pc = 3;
    step();
    checks++; if (resp_instr !== NEW3) begin
      errors++; $display("FAIL oor_write_ignored got i=%h want i=%h", resp_instr, NEW3); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_hold();
    req_valid = 1'b1; req_pc = 2; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_instr !== M2) begin
      errors++; $display("FAIL rst_hold_pre got v=%b i=%h want v=1 i=%h", resp_valid, resp_instr, M2); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_instr !== '0 || resp_pc !== '0) begin
      errors++; $display("FAIL rst_async got v=%b i=%h pc=%0d want v=0 i=0 pc=0", resp_valid, resp_instr, resp_pc); end
    rst_n = 1'b1;
    step();
    req_valid = 1'b1; req_pc = 0; resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_instr !== M0) begin
      errors++; $display("FAIL rst_mem_kept got v=%b i=%h want v=1 i=%h", resp_valid, resp_instr, M0); end
    req_valid = 1'b0;
    step();
  endtask

`ifdef INST_MEM_PARITY_EN
  task automatic test_parity();
    req_valid = 1'b1; req_pc = 1; resp_ready = 1'b1;
    step();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got %b want 0", parity_err); end
    req_valid = 1'b0;
    dut.u_array.mem[1] = dut.u_array.mem[1] ^ (20'h1 << INST_W);
    step();
    req_valid = 1'b1; req_pc = 1;
    step();
    checks++; if (resp_valid !== 1'b1 || parity_err !== 1'b1) begin
      errors++; $display("FAIL parity_flip got v=%b p=%b want v=1 p=1", resp_valid, parity_err); end
    req_pc = 20;
    step();
    checks++; if (resp_fault !== 1'b1 || parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_oor got f=%b p=%b want f=1 p=0", resp_fault, parity_err); end
    req_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_hold();
    test_flush();
    test_write_first();
    test_reset_hold();
`ifdef INST_MEM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
